wave_lsu: RTL

//   Parametrised load/store unit with integrated data memory for the WaveRV core.

---
 rtl/wave_lsu.sv | 130 +++++++++++++
 1 files changed

// File: rtl/wave_lsu.sv
// wave_lsu: handshaked load/store unit with byte/half/word access and integrated data memory.
// Define WAVE_LSU_FAULT_EN to report illegal/misaligned/out-of-range requests on rsp_fault.
module wave_lsu #(
    parameter int ADDR_WIDTH   = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY - 1);

    state_t                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d, lane_q, lane_d, lane_n;
    logic [2:0]            f3_q, f3_d, f3_n;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic                  store_q, store_d, fault_q, fault_d, illegal, fault, we;
    logic [31:0]           wdata_q, wdata_d, rdata_q, rdata_d, word, load_data, wrep;
    logic [15:0]           half;
    logic [7:0]            byte_v;
    logic [3:0]            mask;
    logic [31:0]           mem [2**ADDR_WIDTH];

    // Illegal encodings are normalised to a word access; lanes are force-aligned to the size.
    assign illegal = req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11 || (req_funct3[2] && req_store);
    assign f3_n    = illegal ? 3'b010 : req_funct3;
    assign lane_n  = f3_n[1] ? 2'b00 : f3_n[0] ? {req_addr[1], 1'b0} : req_addr[1:0];
`ifdef WAVE_LSU_FAULT_EN
    assign fault = illegal
                || (req_funct3[1:0] == 2'b01 && req_addr[0])
                || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
                || req_addr[31:ADDR_WIDTH+2] != '0;
`else
    logic unused_addr;
    assign unused_addr = ^req_addr[31:ADDR_WIDTH+2];
    assign fault       = 1'b0;
`endif

    assign word      = mem[idx_q];
    assign half      = lane_q[1] ? word[31:16] : word[15:0];
    assign byte_v    = lane_q[0] ? half[15:8] : half[7:0];
    assign load_data = f3_q[1] ? word
                     : f3_q[0] ? {{16{~f3_q[2] & half[15]}}, half}
                     : {{24{~f3_q[2] & byte_v[7]}}, byte_v};
    assign mask      = f3_q[1] ? 4'hf : f3_q[0] ? 4'b0011 << {lane_q[1], 1'b0} : 4'b0001 << lane_q;
    assign wrep      = f3_q[1] ? wdata_q : f3_q[0] ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};
    assign we        = state_q == ACCESS && cnt_q == 2'd0 && store_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lane_d  = lane_q;
        f3_d    = f3_q;
        idx_d   = idx_q;
        store_d = store_q;
        wdata_d = wdata_q;
        fault_d = fault_q;
        rdata_d = rdata_q;
        if (state_q == IDLE && req_valid) begin
            state_d = fault ? RESP : ACCESS;
            cnt_d   = CNT_INIT;
            lane_d  = lane_n;
            f3_d    = f3_n;
            idx_d   = req_addr[ADDR_WIDTH+1:2];
            store_d = req_store;
            wdata_d = req_wdata;
            fault_d = fault;
            rdata_d = '0;
        end else if (state_q == ACCESS) begin
            cnt_d = cnt_q - 2'd1;
            if (cnt_q == 2'd0) begin
                state_d = RESP;
                rdata_d = store_q ? '0 : load_data;
            end
        end else if (state_q == RESP && rsp_ready) begin
            state_d = IDLE;
            rdata_d = '0;
            fault_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lane_q  <= '0;
            f3_q    <= '0;
            idx_q   <= '0;
            store_q <= 1'b0;
            wdata_q <= '0;
            fault_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lane_q  <= lane_d;
            f3_q    <= f3_d;
            idx_q   <= idx_d;
            store_q <= store_d;
            wdata_q <= wdata_d;
            fault_q <= fault_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (mask[i]) mem[idx_q][8*i +: 8] <= wrep[8*i +: 8];
            end
        end
    end

    assign req_ready = state_q == IDLE;
    assign busy      = state_q != IDLE;
    assign rsp_valid = state_q == RESP;
    assign rsp_rdata = rdata_q;
    assign rsp_fault = fault_q;
endmodule
